// File: rtl/cp0_regfile.sv
// rtl/cp0_regfile.sv - CP0 register file (Status, Cause, EPC, Count, Compare); optional timer via CP0_TIMER_EN
module cp0_regfile #(
    parameter int DATA_WIDTH     = 32,
    parameter int COUNT_DIV_LOG2 = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_wb_cp0,
    input  logic [4:0]            wb_cp0_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_cp0_write,
    input  logic [4:0]            cp0_read_addr,
    output logic [DATA_WIDTH-1:0] cp0_read,
    input  logic                  exc_valid,
    input  logic [4:0]            exc_code,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    input  logic                  exc_in_delay,
    input  logic                  eret,
    input  logic [5:0]            int_i,
    output logic [DATA_WIDTH-1:0] cp0_status,
    output logic [DATA_WIDTH-1:0] cp0_cause,
    output logic [DATA_WIDTH-1:0] cp0_epc,
    output logic                  int_pending,
    output logic                  timer_int
);

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    // Status fields
    logic [7:0] r_status_im;
    logic       r_status_exl;
    logic       r_status_ie;

    // Cause fields
    logic       r_cause_bd;
    logic [5:0] r_cause_ip_hw;
    logic [1:0] r_cause_ip_sw;
    logic [4:0] r_cause_exc;

    logic [DATA_WIDTH-1:0] r_epc;

    // An MTC0 only commits when neither an exception nor an ERET claims the cycle.
    logic w_mtc0_en;
    logic w_wr_status;
    logic w_wr_cause;
    logic w_wr_epc;
    logic w_timer_int;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_cause;

    assign w_mtc0_en   = wb_wb_cp0 & ~exc_valid & ~eret;
    assign w_wr_status = w_mtc0_en && (wb_cp0_write_addr == REG_STATUS);
    assign w_wr_cause  = w_mtc0_en && (wb_cp0_write_addr == REG_CAUSE);
    assign w_wr_epc    = w_mtc0_en && (wb_cp0_write_addr == REG_EPC);

    // Status: exception sets EXL, ERET clears it, otherwise MTC0 writes the masked fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status_im  <= 8'h00;
            r_status_exl <= 1'b0;
            r_status_ie  <= 1'b0;
        end else if (exc_valid) begin
            r_status_exl <= 1'b1;
        end else if (eret) begin
            r_status_exl <= 1'b0;
        end else if (w_wr_status) begin
            r_status_im  <= wb_cp0_write[15:8];
            r_status_exl <= wb_cp0_write[1];
            r_status_ie  <= wb_cp0_write[0];
        end
    end

    // Cause: hardware lines sampled every cycle; BD only recorded on the outermost exception.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cause_bd    <= 1'b0;
            r_cause_ip_hw <= 6'd0;
            r_cause_ip_sw <= 2'd0;
            r_cause_exc   <= 5'd0;
        end else begin
            r_cause_ip_hw <= int_i;
            if (exc_valid) begin
                r_cause_exc <= exc_code;
                if (!r_status_exl) begin
                    r_cause_bd <= exc_in_delay;
                end
            end else if (w_wr_cause) begin
                r_cause_ip_sw <= wb_cp0_write[9:8];
            end
        end
    end

    // EPC: a delay-slot fault restarts at the branch, one word earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_epc <= '0;
        end else if (exc_valid) begin
            if (!r_status_exl) begin
                r_epc <= exc_in_delay ? (exc_pc - DATA_WIDTH'(4)) : exc_pc;
            end
        end else if (w_wr_epc) begin
            r_epc <= wb_cp0_write;
        end
    end

`ifdef CP0_TIMER_EN
    localparam int PW = (COUNT_DIV_LOG2 > 0) ? COUNT_DIV_LOG2 : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'((1 << COUNT_DIV_LOG2) - 1);

    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] r_compare;
    logic [PW-1:0]         r_presc;
    logic                  r_timer_int;
    logic                  w_wr_count;
    logic                  w_wr_compare;

    assign w_wr_count   = w_mtc0_en && (wb_cp0_write_addr == REG_COUNT);
    assign w_wr_compare = w_mtc0_en && (wb_cp0_write_addr == REG_COMPARE);

    // Count with prescaler; a Count write reloads the value and restarts the prescaler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_presc <= '0;
        end else if (w_wr_count) begin
            r_count <= wb_cp0_write;
            r_presc <= '0;
        end else if (r_presc == PRESC_MAX) begin
            r_count <= r_count + DATA_WIDTH'(1);
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Compare and timer flag: writing Compare acknowledges the interrupt, even on a match edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_compare   <= '0;
            r_timer_int <= 1'b0;
        end else if (w_wr_compare) begin
            r_compare   <= wb_cp0_write;
            r_timer_int <= 1'b0;
        end else if (r_count == r_compare) begin
            r_timer_int <= 1'b1;
        end
    end

    assign w_timer_int = r_timer_int;
`else
    assign w_timer_int = 1'b0;
`endif

    assign w_status = {16'd0, r_status_im, 6'd0, r_status_exl, r_status_ie};
    assign w_cause  = {r_cause_bd, 15'd0, r_cause_ip_hw[5] | w_timer_int, r_cause_ip_hw[4:0],
                       r_cause_ip_sw, 1'b0, r_cause_exc, 2'b00};

    // MFC0 read mux over the current register contents; unmapped numbers read zero.
    always_comb begin
        cp0_read = '0;
        case (cp0_read_addr)
`ifdef CP0_TIMER_EN
            REG_COUNT:   cp0_read = r_count;
            REG_COMPARE: cp0_read = r_compare;
`endif
            REG_STATUS:  cp0_read = w_status;
            REG_CAUSE:   cp0_read = w_cause;
            REG_EPC:     cp0_read = r_epc;
            default:     cp0_read = '0;
        endcase
    end

    assign cp0_status  = w_status;
    assign cp0_cause   = w_cause;
    assign cp0_epc     = r_epc;
    assign timer_int   = w_timer_int;
    assign int_pending = r_status_ie & ~r_status_exl & (|(r_status_im & w_cause[15:8]));

endmodule
